// File: rtl/bit_deserializer.sv
// bit_deserializer: LSB-first bit-serial to parallel word assembler.
// Bits are accepted one per cycle into an assembly register. Each completed
// frame is handed off to a one-entry valid/ready output buffer.
// Optional feature: define BIT_DESER_PARITY_EN to append one even-parity bit
// to every frame. perr then reports the parity check for the buffered word.
module bit_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         bit_valid,
    input  logic                         bit_in,
    output logic                         bit_ready,
    output logic                         word_valid,
    output logic [WIDTH-1:0]             word,
    input  logic                         word_ready,
    output logic [$clog2(WIDTH+1)-1:0]   bit_idx,
    output logic                         perr
);

    localparam int IDX_W = $clog2(WIDTH + 1);
`ifdef BIT_DESER_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FL - 1);

    logic [IDX_W-1:0] bit_idx_reg;
    logic [IDX_W-1:0] bit_idx_next;
    logic [WIDTH-1:0] asm_reg;
    logic [WIDTH-1:0] asm_next;
    logic [WIDTH-1:0] word_reg;
    logic [WIDTH-1:0] word_next;
    logic             word_valid_reg;
    logic             word_valid_next;
    logic             at_last;
    logic             bit_accept;
    logic             frame_done;

    // The final bit of a frame is the only one that needs a free output
    // slot; a drain in the same cycle frees the slot.
    assign at_last    = (bit_idx_reg == LAST_IDX);
    assign bit_ready  = !(at_last && word_valid_reg && !word_ready);
    assign bit_accept = bit_valid && bit_ready;
    assign frame_done = bit_accept && at_last;

    // Each assembly bit captures bit_in when the frame position matches it.
    // The parity position (if any) matches no data bit and leaves asm alone.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_asm_bit
            assign asm_next[gi] = (bit_accept && (bit_idx_reg == IDX_W'(gi)))
                                  ? bit_in : asm_reg[gi];
        end
    endgenerate

    // Frame position: advance on every accepted bit, wrap after the last one.
    always_comb begin
        bit_idx_next = bit_idx_reg;
        if (bit_accept) begin
            if (at_last) begin
                bit_idx_next = '0;
            end else begin
                bit_idx_next = bit_idx_reg + IDX_W'(1);
            end
        end
    end

    // Output buffer: a completed frame always wins over a drain, so a
    // simultaneous load and drain keeps valid high with the new word.
    always_comb begin
        word_next       = word_reg;
        word_valid_next = word_valid_reg;
        if (frame_done) begin
            word_next       = asm_next;
            word_valid_next = 1'b1;
        end else if (word_valid_reg && word_ready) begin
            word_valid_next = 1'b0;
        end
    end

    // State registers; reset discards any partial frame and buffered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx_reg    <= '0;
            asm_reg        <= '0;
            word_reg       <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            bit_idx_reg    <= bit_idx_next;
            asm_reg        <= asm_next;
            word_reg       <= word_next;
            word_valid_reg <= word_valid_next;
        end
    end

`ifdef BIT_DESER_PARITY_EN
    logic perr_reg;
    logic perr_next;

    // Even parity: data bits XOR parity bit must be 0. The flag travels
    // with the word it was computed for.
    always_comb begin
        perr_next = perr_reg;
        if (frame_done) begin
            perr_next = (^asm_reg) ^ bit_in;
        end
    end

    // Parity flag register, loaded on the same edge as word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_reg <= 1'b0;
        end else begin
            perr_reg <= perr_next;
        end
    end

    assign perr = perr_reg;
`else
    assign perr = 1'b0;
`endif

    assign bit_idx    = bit_idx_reg;
    assign word       = word_reg;
    assign word_valid = word_valid_reg;

endmodule

// File: tb/tb_bit_deserializer.sv
// Testbench for bit_deserializer: directed serial frames, a frame-level
// reference model compared every cycle, and literal spot checks.
// Honours BIT_DESER_PARITY_EN when the design is built with it.
module tb_bit_deserializer;

    localparam int WIDTH = 4;
    localparam int IDX_W = $clog2(WIDTH + 1);
`ifdef BIT_DESER_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    logic             clk;
    logic             rst_n;
    logic             bit_valid;
    logic             bit_in;
    logic             bit_ready;
    logic             word_valid;
    logic [WIDTH-1:0] word;
    logic             word_ready;
    logic [IDX_W-1:0] bit_idx;
    logic             perr;

    int n_checks;
    int n_fail;
    int stalls;

    bit_deserializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .word_valid (word_valid),
        .word       (word),
        .word_ready (word_ready),
        .bit_idx    (bit_idx),
        .perr       (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    int m_pos;              // number of bits collected in the current frame
    int m_bits[FL];         // bits of the current frame in arrival order
    bit m_vld;
    int m_word;
    int m_perr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos  = 0;
            m_vld  = 0;
            m_word = 0;
            m_perr = 0;
            for (int i = 0; i < FL; i++) m_bits[i] = 0;
        end else begin
            bit full_block;
            bit loaded;
            full_block = (m_pos == FL - 1) && m_vld && !word_ready;
            loaded = 0;
            if (bit_valid && !full_block) begin
                m_bits[m_pos] = int'(bit_in);
                if (m_pos == FL - 1) begin
                    int w;
                    int p;
                    w = 0;
                    p = 0;
                    for (int i = 0; i < WIDTH; i++) w += m_bits[i] * (1 << i);
                    for (int i = 0; i < FL; i++) p ^= m_bits[i];
                    m_word = w;
`ifdef BIT_DESER_PARITY_EN
                    m_perr = p;
`else
                    m_perr = 0;
`endif
                    loaded = 1;
                    m_pos  = 0;
                end else begin
                    m_pos++;
                end
            end
            if (loaded) m_vld = 1;
            else if (m_vld && word_ready) m_vld = 0;
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        int exp_ready;
        exp_ready = ((m_pos == FL - 1) && m_vld && !word_ready) ? 0 : 1;
        chk("model bit_ready", int'(bit_ready), exp_ready);
        chk("model word_valid", int'(word_valid), int'(m_vld));
        chk("model bit_idx", int'(bit_idx), m_pos);
        chk("model perr", int'(perr), m_perr);
        if (m_vld) chk("model word", int'(word), m_word);
    end

    // ---------------- stimulus helpers ----------------
    // Present one bit and hold it until it is accepted (bounded).
    task automatic send_bit(input bit b);
        int   guard;
        logic acc;
        bit_valid = 1'b1;
        bit_in    = b;
        guard     = 0;
        do begin
            @(negedge clk);
            acc = bit_ready;
            @(posedge clk);
            #1;
            if (!acc) stalls++;
            guard++;
        end while (!acc && guard < 50);
        if (!acc) chk("send_bit timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input int w);
        for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
    endtask

    task automatic send_parity(input int w, input bit flip);
        bit p;
        p = 0;
        for (int i = 0; i < WIDTH; i++) p ^= w[i];
`ifdef BIT_DESER_PARITY_EN
        send_bit(p ^ flip);
`endif
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        stalls     = 0;
        rst_n      = 1'b0;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        word_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset bit_idx", int'(bit_idx), 0);
        chk("reset word", int'(word), 0);
        chk("reset word_valid", int'(word_valid), 0);
        chk("reset bit_ready", int'(bit_ready), 1);
        chk("reset perr", int'(perr), 0);
        rst_n = 1'b1;
        idle(1);

        // 1,0,1,0 -> 5, valid for one cycle
        send_word(4'b0101);
        send_parity(5, 0);
        bit_valid = 1'b0;
        chk("t1 word", int'(word), 5);
        chk("t1 word_valid", int'(word_valid), 1);
        chk("t1 bit_idx", int'(bit_idx), 0);
        idle(1);
        chk("t1 valid pulse", int'(word_valid), 0);

        // back-to-back frames 6 then 15, no stalls
        stalls = 0;
        send_word(4'b0110);
        send_parity(6, 0);
        chk("t2 word a", int'(word), 6);
        chk("t2 valid a", int'(word_valid), 1);
        send_word(4'b1111);
        send_parity(15, 0);
        bit_valid = 1'b0;
        chk("t2 word b", int'(word), 15);
        chk("t2 stalls", stalls, 0);
        idle(2);

        // backpressure: hold word 5, next frame stalls at its last bit
        send_word(4'b0101);
        send_parity(5, 0);
        #1 word_ready = 1'b0;
        stalls = 0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
`ifdef BIT_DESER_PARITY_EN
        send_bit(1'b0);
        bit_in = 1'b0;   // parity of 0110 is 0
`else
        bit_in = 1'b0;
`endif
        chk("t3 no early stall", stalls, 0);
        @(negedge clk);
        chk("t3 bit_ready low", int'(bit_ready), 0);
        chk("t3 bit_idx", int'(bit_idx), FL - 1);
        @(negedge clk);
        chk("t3 word held", int'(word), 5);
        #1 word_ready = 1'b1;
        #1 chk("t3 bit_ready back", int'(bit_ready), 1);
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        chk("t3 new word", int'(word), 6);
        chk("t3 valid kept", int'(word_valid), 1);
        chk("t3 bit_idx wrap", int'(bit_idx), 0);
        idle(2);

        // reset mid-frame with a buffered word
        word_ready = 1'b0;
        send_word(4'b1001);
        send_parity(9, 0);
        send_bit(1'b1);
        send_bit(1'b1);
        bit_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t4 rst bit_idx", int'(bit_idx), 0);
        chk("t4 rst word_valid", int'(word_valid), 0);
        chk("t4 rst word", int'(word), 0);
        chk("t4 rst bit_ready", int'(bit_ready), 1);
        idle(2);
        rst_n = 1'b1;
        word_ready = 1'b1;
        idle(1);
        send_word(4'b0110);
        send_parity(6, 0);
        bit_valid = 1'b0;
        chk("t4 word after reset", int'(word), 6);
        idle(2);

`ifdef BIT_DESER_PARITY_EN
        // parity good then bad
        send_word(4'b0101);
        send_bit(1'b0);
        bit_valid = 1'b0;
        chk("t5 word good", int'(word), 5);
        chk("t5 perr good", int'(perr), 0);
        send_word(4'b0101);
        send_bit(1'b1);
        bit_valid = 1'b0;
        chk("t5 word bad", int'(word), 5);
        chk("t5 perr bad", int'(perr), 1);
        idle(2);
`endif

        // gaps of 3 idle cycles between bits 1,1,0,0 -> 3
        send_bit(1'b1);
        idle(3);
        chk("t6 idx hold 1", int'(bit_idx), 1);
        send_bit(1'b1);
        idle(3);
        chk("t6 idx hold 2", int'(bit_idx), 2);
        send_bit(1'b0);
        idle(3);
        chk("t6 idx hold 3", int'(bit_idx), 3);
        send_bit(1'b0);
`ifdef BIT_DESER_PARITY_EN
        idle(3);
        send_bit(1'b0);
`endif
        bit_valid = 1'b0;
        chk("t6 word", int'(word), 3);
        chk("t6 word_valid", int'(word_valid), 1);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bit_deserializer.md
# bit_deserializer

Bit-serial to parallel word assembler, the receive end of the LSB-first bit-by-bit word transfer used in our loop-ordering regressions. It accepts one bit per cycle, places bit i of a frame into word position i (index 0 first), and presents each completed word through a one-entry valid/ready output buffer. It sits between a serial bit source and a word-wide consumer, and exercises sequential behaviour on the same index ordering that our combinational copy loops check.

## Interface
- WIDTH, 4, bits per word; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial data bit, LSB of the word first.
- bit_ready  output  1  block accepts bit_in this cycle.
- word_valid  output  1  word holds a completed frame.
- word  output  WIDTH  assembled word.
- word_ready  input  1  consumer takes word this cycle.
- bit_idx  output  $clog2(WIDTH+1)  position of the next bit expected in the current frame.
- perr  output  1  parity error flag for the current word. Tied 0 unless the parity option is compiled in.

## Operation
- Bit handshake: a bit transfers when bit_valid && bit_ready at a rising edge.
- Frame length FL is WIDTH, or WIDTH+1 with parity.
- Frame assembly:
  - bit_idx counts 0..FL-1.
  - A bit accepted at bit_idx = k < WIDTH is written to asm[k], and bit_idx increments.
  - Accepting the last frame bit resets bit_idx to 0 (wrap-around).
- Word hand-off: accepting the last bit loads word with the complete frame in that same edge, and sets word_valid. Final data bit goes to word[WIDTH-1].
- Output buffer: word_valid clears on word_valid && word_ready unless a new word is loaded in that same edge. A simultaneous load and drain keeps word_valid = 1 and shows the new word.
- Backpressure:
  - bit_ready = 0 only when bit_idx = FL-1 && word_valid && !word_ready.
  - Non-final bits are always accepted into the assembly register, even while the output buffer is full.
- No bit is ever dropped or duplicated. word is stable while word_valid && !word_ready.
- Idle cycles (bit_valid = 0) mid-frame do not change assembly state.
- Reset values: bit_idx 0, asm 0, word 0, word_valid 0, perr 0, bit_ready 1.
- Reset asserted mid-frame discards the partial frame and any buffered word. The first bit after reset release is bit 0.

## Timing
- Latency: word_valid rises on the edge that accepts the last frame bit, so it is visible 1 cycle after that bit is presented.
- Throughput: one word per FL cycles sustained when word_ready = 1 throughout; no bubbles between frames.
- bit_ready is combinational from bit_idx, word_valid and word_ready. There is no combinational path from bit_valid to bit_ready.
- word_valid, word, perr and bit_idx are registered outputs.

## Configuration
- BIT_DESER_PARITY_EN defined:
  - Frame is WIDTH data bits plus one trailing even-parity bit.
  - The parity bit is accepted at bit_idx = WIDTH.
  - Hand-off happens on the parity bit. perr loads 1 if the XOR of the data bits and the parity bit is 1, else 0.
  - The word is delivered regardless of perr, and perr is held alongside word.
- BIT_DESER_PARITY_EN undefined: frame is WIDTH bits, perr is constant 0, and bit_idx never reaches WIDTH.

## Test plan
- Serial 1,0,1,0 with word_ready = 1 → word = 4'b0101 (5), word_valid high for 1 cycle, bit_idx back to 0.
- Frames 0,1,1,0 then 1,1,1,1 back-to-back → words 6 then 15 on cycles 4 and 8, with no bit_ready deassertion.
- word_ready held 0 after word 5: the next frame's bits 0..2 are accepted, then bit_ready = 0 at bit_idx 3. Raising word_ready drains 5, and the next edge loads the new word with word_valid staying 1.
- Reset pulsed after 2 bits of a frame: all outputs return to reset values, and the next 4 bits 0,1,1,0 yield word 6.
- With BIT_DESER_PARITY_EN: data 1,0,1,0 then parity 0 → word 5, perr 0. Same data with parity 1 → word 5, perr 1.
- bit_valid gaps of 3 idle cycles between each bit of 1,1,0,0 → word 3, bit_idx holds across the gaps.
